// File: rtl/game_round_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_round_sequencer_if
//
// Purpose: bundles every non-clock/reset signal between the game round
// sequencer and its neighbours (login/difficulty logic, prompt ROM and
// answer decoder) so they travel as one port.
//
// Signals:
//   logged_in      level, 1 while a user is logged in
//   difficulty     2 bit, 00 none / 01 easy / 10 medium / 11 hard
//   start          one-cycle pulse, begins a game
//   tick           one-cycle timebase enable
//   answer_valid   one-cycle pulse, player answer decoded
//   answer_correct qualifies answer_valid
//   rom_addr       6 bit prompt ROM address {difficulty, round}
//   rom_rd         ROM read strobe, data valid the cycle after
//   prompt_valid   high while waiting for an answer
//   round          4 bit current round index, 0-based
//   score          5 bit correct answers this game
//   strikes        4 bit wrong or timed-out answers this game
//   busy           high in LOAD, PROMPT and SCORE
//   game_over      high once the game has ended
//   logout         one-cycle pulse when the user logs out mid-session
//
// Modports:
//   master  drives the inputs of the sequencer (system side / testbench)
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface game_round_sequencer_if;
    logic       logged_in;
    logic [1:0] difficulty;
    logic       start;
    logic       tick;
    logic       answer_valid;
    logic       answer_correct;
    logic [5:0] rom_addr;
    logic       rom_rd;
    logic       prompt_valid;
    logic [3:0] round;
    logic [4:0] score;
    logic [3:0] strikes;
    logic       busy;
    logic       game_over;
    logic       logout;

    modport master (
        output logged_in, difficulty, start, tick, answer_valid, answer_correct,
        input  rom_addr, rom_rd, prompt_valid, round, score, strikes,
               busy, game_over, logout
    );

    modport slave (
        input  logged_in, difficulty, start, tick, answer_valid, answer_correct,
        output rom_addr, rom_rd, prompt_valid, round, score, strikes,
               busy, game_over, logout
    );
endinterface

// File: rtl/game_round_sequencer.sv
// ---------------------------------------------------------------------------
// game_round_sequencer
//
// Purpose: runs one Morse-game session after login. Latches the chosen
// difficulty, walks the prompt ROM one round at a time, waits for either a
// decoded answer or a difficulty-dependent tick timeout, and keeps score and
// strikes until the game ends (all rounds played or too many strikes).
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    game_round_sequencer_if.slave, carrying the handshake signals
//          (see the interface file for the per-signal description)
//
// All outputs are registered and updated inside the single FSM block.
// ---------------------------------------------------------------------------
module game_round_sequencer #(
    parameter int unsigned ROUNDS      = 8,
    parameter int unsigned MAX_STRIKES = 3,
    parameter int unsigned EASY_TICKS  = 10,
    parameter int unsigned MED_TICKS   = 6,
    parameter int unsigned HARD_TICKS  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    game_round_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_ROM,
        PROMPT,
        SCORE,
        DONE
    } state_t;

    state_t     state_q;
    logic [1:0] diff_q;
    logic [3:0] round_q;
    logic [4:0] score_q;
    logic [3:0] strikes_q;
    logic [7:0] tick_cnt_q;
    logic       correct_q;
    logic [5:0] rom_addr_q;
    logic       rom_rd_q;
    logic       prompt_valid_q;
    logic       busy_q;
    logic       game_over_q;
    logic       logout_q;

    logic [7:0] tick_limit;
    logic [4:0] score_d;
    logic [3:0] strikes_d;
    logic [3:0] round_next;
    logic       game_ends;
    logic       start_ok;

    // Helper terms shared by the FSM: the per-difficulty timeout, the score
    // and strike values SCORE is about to commit, and whether those updated
    // values finish the game. The end-of-game test must see the updated
    // strikes, otherwise the game would run one round too long.
    always_comb begin
        tick_limit = 8'(EASY_TICKS);
        case (diff_q)
            2'b10:   tick_limit = 8'(MED_TICKS);
            2'b11:   tick_limit = 8'(HARD_TICKS);
            default: tick_limit = 8'(EASY_TICKS);
        endcase

        score_d   = correct_q ? (score_q + 5'd1) : score_q;
        strikes_d = correct_q ? strikes_q : (strikes_q + 4'd1);
        round_next = round_q + 4'd1;
        game_ends = (strikes_d == 4'(MAX_STRIKES)) || (round_q == 4'(ROUNDS - 1));
        start_ok  = bus.start && bus.logged_in && (bus.difficulty != 2'b00);
    end

    // Main session FSM. Losing the login outranks every other transition,
    // so it is tested before the per-state case. rom_rd and logout are
    // one-cycle strobes and fall back to 0 unless a branch sets them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            diff_q         <= 2'b00;
            round_q        <= 4'd0;
            score_q        <= 5'd0;
            strikes_q      <= 4'd0;
            tick_cnt_q     <= 8'd0;
            correct_q      <= 1'b0;
            rom_addr_q     <= 6'd0;
            rom_rd_q       <= 1'b0;
            prompt_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            game_over_q    <= 1'b0;
            logout_q       <= 1'b0;
        end else begin
            rom_rd_q <= 1'b0;
            logout_q <= 1'b0;

            if ((state_q != IDLE) && !bus.logged_in) begin
                state_q        <= IDLE;
                busy_q         <= 1'b0;
                prompt_valid_q <= 1'b0;
                game_over_q    <= 1'b0;
                logout_q       <= 1'b1;
                round_q        <= 4'd0;
                score_q        <= 5'd0;
                strikes_q      <= 4'd0;
            end else begin
                case (state_q)
                    // IDLE and DONE both accept a fresh game; difficulty is
                    // captured here and never looked at again until the
                    // next start.
                    IDLE, DONE: begin
                        if (start_ok) begin
                            state_q     <= LOAD;
                            diff_q      <= bus.difficulty;
                            round_q     <= 4'd0;
                            score_q     <= 5'd0;
                            strikes_q   <= 4'd0;
                            rom_rd_q    <= 1'b1;
                            rom_addr_q  <= {bus.difficulty, 4'd0};
                            busy_q      <= 1'b1;
                            game_over_q <= 1'b0;
                        end
                    end

                    // The ROM strobe and address were registered on entry,
                    // so LOAD only has to move on.
                    LOAD: begin
                        state_q <= WAIT_ROM;
                        busy_q  <= 1'b0;
                    end

                    WAIT_ROM: begin
                        state_q        <= PROMPT;
                        tick_cnt_q     <= 8'd0;
                        busy_q         <= 1'b1;
                        prompt_valid_q <= 1'b1;
                    end

                    // An answer in the same cycle as the timeout tick wins
                    // because it is tested first.
                    PROMPT: begin
                        if (bus.answer_valid) begin
                            state_q        <= SCORE;
                            correct_q      <= bus.answer_correct;
                            prompt_valid_q <= 1'b0;
                        end else if (bus.tick) begin
                            if (tick_cnt_q == (tick_limit - 8'd1)) begin
                                state_q        <= SCORE;
                                correct_q      <= 1'b0;
                                prompt_valid_q <= 1'b0;
                            end else begin
                                tick_cnt_q <= tick_cnt_q + 8'd1;
                            end
                        end
                    end

                    // Commit the result, then either finish or set up the
                    // next round's ROM read directly so LOAD follows at once.
                    SCORE: begin
                        score_q   <= score_d;
                        strikes_q <= strikes_d;
                        if (game_ends) begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q    <= LOAD;
                            round_q    <= round_next;
                            rom_rd_q   <= 1'b1;
                            rom_addr_q <= {diff_q, round_next};
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rom_addr     = rom_addr_q;
    assign bus.rom_rd       = rom_rd_q;
    assign bus.prompt_valid = prompt_valid_q;
    assign bus.round        = round_q;
    assign bus.score        = score_q;
    assign bus.strikes      = strikes_q;
    assign bus.busy         = busy_q;
    assign bus.game_over    = game_over_q;
    assign bus.logout       = logout_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_round_sequencer
//
// Self-checking bench for game_round_sequencer. A table of start-acceptance
// vectors, several directed game sequences and a batch of randomized games
// are all checked against a round-level model of the game rules
// (score/strikes/round bookkeeping plus per-difficulty tick limits).
// ---------------------------------------------------------------------------
module tb_game_round_sequencer;

    localparam int ROUNDS      = 8;
    localparam int MAX_STRIKES = 3;
    localparam int EASY_TICKS  = 10;
    localparam int MED_TICKS   = 6;
    localparam int HARD_TICKS  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    game_round_sequencer_if bus ();

    game_round_sequencer #(
        .ROUNDS      (ROUNDS),
        .MAX_STRIKES (MAX_STRIKES),
        .EASY_TICKS  (EASY_TICKS),
        .MED_TICKS   (MED_TICKS),
        .HARD_TICKS  (HARD_TICKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Round-level model of the game in progress
    int mRound;
    int mScore;
    int mStrikes;
    int mDiff;
    bit mOver;

    typedef struct {
        logic       li;
        logic [1:0] diff;
        logic       st;
        logic       expRd;
        logic [5:0] expAddr;
    } vec_t;

    vec_t vecs [7];

    // Single comparison point; every check goes through here
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int limitFor(input int d);
        case (d)
            2:       return MED_TICKS;
            3:       return HARD_TICKS;
            default: return EASY_TICKS;
        endcase
    endfunction

    task automatic clearModel();
        mRound   = 0;
        mScore   = 0;
        mStrikes = 0;
        mOver    = 1'b0;
    endtask

    // Start a game from IDLE or DONE; afterwards the DUT sits in LOAD
    task automatic startGame(input int d);
        bus.logged_in  = 1'b1;
        bus.difficulty = 2'(d);
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        mDiff = d;
        clearModel();
    endtask

    // Drop the login and check the logout pulse and cleared counters
    task automatic dropLogin();
        bus.logged_in = 1'b0;
        step();
        checkOutput("logoutPulse", bus.logout, 1);
        checkOutput("logoutBusy", bus.busy, 0);
        checkOutput("logoutPrompt", bus.prompt_valid, 0);
        checkOutput("logoutGameOver", bus.game_over, 0);
        checkOutput("logoutRound", bus.round, 0);
        checkOutput("logoutScore", bus.score, 0);
        checkOutput("logoutStrikes", bus.strikes, 0);
        step();
        checkOutput("logoutOneCycle", bus.logout, 0);
        clearModel();
    endtask

    // One table vector from IDLE: apply, observe acceptance, return to IDLE
    task automatic applyStimulus(input vec_t v);
        bus.logged_in  = v.li;
        bus.difficulty = v.diff;
        bus.start      = v.st;
        step();
        bus.start = 1'b0;
        checkOutput("vecRomRd", bus.rom_rd, 32'(v.expRd));
        checkOutput("vecBusy", bus.busy, 32'(v.expRd));
        checkOutput("vecLogoutIdle", bus.logout, 0);
        if (v.expRd) begin
            checkOutput("vecRomAddr", bus.rom_addr, 32'(v.expAddr));
            dropLogin();
        end else begin
            step();
            checkOutput("vecRomRdStill", bus.rom_rd, 0);
            checkOutput("vecBusyStill", bus.busy, 0);
        end
    endtask

    // Play one round.
    //   mode 0: nTicks ticks, then an answer with the given correctness
    //   mode 1: no answer, ticks until the round times out
    //   mode 2: nTicks ticks, then an answer together with one more tick
    // gap is the number of clocks between tick pulses.
    task automatic playRound(input int mode, input bit corr, input int nTicks, input int gap);
        int         n;
        int         ticks;
        int         lim;
        bit         answered;
        logic [5:0] expAddr;

        n = 0;
        while (!bus.rom_rd && n < 40) begin
            step();
            n++;
        end
        checkOutput("romRdSeen", bus.rom_rd, 1);
        if (!bus.rom_rd) return;

        expAddr = 6'(mDiff * 16 + mRound);
        checkOutput("romAddr", bus.rom_addr, 32'(expAddr));
        checkOutput("loadRound", bus.round, mRound);
        checkOutput("loadScore", bus.score, mScore);
        checkOutput("loadStrikes", bus.strikes, mStrikes);
        checkOutput("loadBusy", bus.busy, 1);

        step();
        checkOutput("waitRomBusy", bus.busy, 0);
        checkOutput("waitRomPrompt", bus.prompt_valid, 0);
        checkOutput("waitRomRd", bus.rom_rd, 0);
        step();
        checkOutput("promptValid", bus.prompt_valid, 1);

        lim = limitFor(mDiff);
        if (mode == 1) begin
            ticks = 0;
            while (bus.prompt_valid && ticks < 20) begin
                bus.tick = 1'b1;
                step();
                bus.tick = 1'b0;
                ticks++;
                if (bus.prompt_valid) repeat (gap - 1) step();
            end
            checkOutput("timeoutTicks", ticks, lim);
            answered = 1'b0;
        end else begin
            for (int i = 0; i < nTicks; i++) begin
                bus.tick = 1'b1;
                step();
                bus.tick = 1'b0;
                repeat (gap - 1) step();
            end
            checkOutput("stillPrompting", bus.prompt_valid, 1);
            if (mode == 2) bus.tick = 1'b1;
            bus.answer_valid   = 1'b1;
            bus.answer_correct = corr;
            step();
            bus.tick           = 1'b0;
            bus.answer_valid   = 1'b0;
            bus.answer_correct = 1'b0;
            answered = 1'b1;
        end

        // SCORE cycle
        checkOutput("scorePrompt", bus.prompt_valid, 0);
        checkOutput("scoreBusy", bus.busy, 1);

        if (answered && corr) mScore++;
        else                  mStrikes++;
        mOver = (mStrikes == MAX_STRIKES) || (mRound == ROUNDS - 1);
        if (!mOver) mRound++;

        // Next rom_rd (or DONE) lands in the third cycle counting the answer cycle
        step();
        checkOutput("afterGameOver", bus.game_over, 32'(mOver));
        checkOutput("afterRomRd", bus.rom_rd, 32'(!mOver));
        checkOutput("afterScore", bus.score, mScore);
        checkOutput("afterStrikes", bus.strikes, mStrikes);
        checkOutput("afterRound", bus.round, mRound);
    endtask

    // Safety net: the run must always reach its summary
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 2'b01, 1'b1, 1'b1, 6'h10};
        vecs[1] = '{1'b1, 2'b10, 1'b1, 1'b1, 6'h20};
        vecs[2] = '{1'b1, 2'b11, 1'b1, 1'b1, 6'h30};
        vecs[3] = '{1'b1, 2'b00, 1'b1, 1'b0, 6'h00};
        vecs[4] = '{1'b0, 2'b01, 1'b1, 1'b0, 6'h00};
        vecs[5] = '{1'b1, 2'b01, 1'b0, 1'b0, 6'h00};
        vecs[6] = '{1'b0, 2'b11, 1'b1, 1'b0, 6'h00};

        bus.logged_in      = 1'b0;
        bus.difficulty     = 2'b00;
        bus.start          = 1'b0;
        bus.tick           = 1'b0;
        bus.answer_valid   = 1'b0;
        bus.answer_correct = 1'b0;
        mDiff = 0;
        clearModel();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstRomAddr", bus.rom_addr, 0);
        checkOutput("rstRomRd", bus.rom_rd, 0);
        checkOutput("rstPrompt", bus.prompt_valid, 0);
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstGameOver", bus.game_over, 0);
        checkOutput("rstLogout", bus.logout, 0);
        checkOutput("rstScore", bus.score, 0);
        rst_n = 1'b1;
        step();

        $display("[TB] start acceptance table");
        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        $display("[TB] reset in the middle of a prompt");
        startGame(1);
        step();
        step();
        checkOutput("midPromptValid", bus.prompt_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRstPrompt", bus.prompt_valid, 0);
        checkOutput("asyncRstBusy", bus.busy, 0);
        checkOutput("asyncRstRomAddr", bus.rom_addr, 0);
        checkOutput("asyncRstLogout", bus.logout, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        checkOutput("postRstLogout", bus.logout, 0);
        checkOutput("postRstBusy", bus.busy, 0);
        step();
        checkOutput("postRstLogout2", bus.logout, 0);
        checkOutput("postRstRomRd", bus.rom_rd, 0);
        clearModel();

        $display("[TB] easy game, all answers correct");
        startGame(1);
        for (int r = 0; r < ROUNDS; r++) playRound(0, 1'b1, int'($urandom_range(0, 3)), 1);
        repeat (2) step();
        checkOutput("easyFinalScore", bus.score, 8);
        checkOutput("easyFinalStrikes", bus.strikes, 0);
        checkOutput("easyFinalRound", bus.round, 7);
        checkOutput("easyGameOver", bus.game_over, 1);

        $display("[TB] hard game, every round times out");
        startGame(3);
        for (int r = 0; r < 3; r++) playRound(1, 1'b0, 0, 4);
        checkOutput("hardGameOver", bus.game_over, 1);
        checkOutput("hardRound", bus.round, 2);
        checkOutput("hardScore", bus.score, 0);
        checkOutput("hardStrikes", bus.strikes, 3);

        $display("[TB] medium game, answer together with the last tick");
        startGame(2);
        playRound(2, 1'b1, MED_TICKS - 1, 1);
        checkOutput("medScore", bus.score, 1);
        checkOutput("medStrikes", bus.strikes, 0);
        dropLogin();

        $display("[TB] difficulty change then logout in round 3");
        startGame(1);
        for (int r = 0; r < 3; r++) playRound(0, 1'b1, 0, 1);
        checkOutput("r3RomRd", bus.rom_rd, 1);
        checkOutput("r3RomAddr", bus.rom_addr, 32'h13);
        step();
        step();
        checkOutput("r3Prompt", bus.prompt_valid, 1);
        bus.difficulty = 2'b11;
        step();
        step();
        checkOutput("r3AddrHeld", bus.rom_addr, 32'h13);
        checkOutput("r3StillPrompt", bus.prompt_valid, 1);
        dropLogin();
        checkOutput("r3AddrAfterLogout", bus.rom_addr, 32'h13);

        $display("[TB] randomized games");
        for (int g = 0; g < 8; g++) begin
            int guard;
            startGame(int'($urandom_range(1, 3)));
            guard = 0;
            while (!mOver && guard < 20) begin
                int mode;
                int lim;
                int pick;
                lim  = limitFor(mDiff);
                pick = int'($urandom_range(0, 9));
                if (pick < 3)      mode = 1;
                else if (pick < 4) mode = 2;
                else               mode = 0;
                playRound(mode, 1'($urandom_range(0, 1)),
                          (mode == 2) ? (lim - 1) : int'($urandom_range(0, lim - 1)),
                          int'($urandom_range(1, 3)));
                guard++;
            end
            checkOutput("randGameOver", bus.game_over, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
